// File: rtl/y86_alu_pkg.sv
// Shared op codes and FSM state encoding for the iterative Y86-64 ALU.
package y86_alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/y86_alu_iter_if.sv
// Request/response bundle between the execute stage (master) and the ALU (slave).
interface y86_alu_iter_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zf;
  logic             sf;
  logic             of;
  logic             cf;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zf, sf, of, cf
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zf, sf, of, cf
  );
endinterface

// File: rtl/alu_chunk_slice.sv
// Combinational CHUNK-bit ripple-carry adder shared by every BUSY cycle.
module alu_chunk_slice #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);
  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i] = x[i] ^ y[i] ^ c;
      c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    cout = c;
  end
endmodule

// File: rtl/y86_alu_iter.sv
// Iterative ADD/SUB/AND/XOR with Y86 flags, CHUNK bits per cycle, LS chunk first.
module y86_alu_iter
  import y86_alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic         clk,
  input  logic         rst,
  y86_alu_iter_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  alu_state_e       state_q, state_d;
  alu_op_e          op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic             zf_q, zf_d, sf_q, sf_d, of_q, of_d, cf_q, cf_d;

  logic [CHUNK-1:0] chunk_a, chunk_b, chunk_sum, chunk_res;
  logic             chunk_cout, is_arith;

  assign chunk_a = a_q[int'(k_q)*CHUNK +: CHUNK];
  assign chunk_b = b_q[int'(k_q)*CHUNK +: CHUNK];

  alu_chunk_slice #(.CHUNK(CHUNK)) u_slice (
    .x    (chunk_a),
    .y    (chunk_b),
    .cin  (carry_q),
    .sum  (chunk_sum),
    .cout (chunk_cout)
  );

  assign is_arith = (op_q == ALU_ADD) || (op_q == ALU_SUB);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    k_d       = k_q;
    carry_d   = carry_q;
    result_d  = result_q;
    zf_d      = zf_q;
    sf_d      = sf_q;
    of_d      = of_q;
    cf_d      = cf_q;
    chunk_res = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_d    = alu_op_e'(bus.op);
          a_d     = bus.a;
          b_d     = (bus.op == ALU_SUB) ? ~bus.b : bus.b;
          carry_d = (bus.op == ALU_SUB);
          k_d     = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        case (op_q)
          ALU_AND: chunk_res = chunk_a & chunk_b;
          ALU_XOR: chunk_res = chunk_a ^ chunk_b;
          default: begin
            chunk_res = chunk_sum;
            carry_d   = chunk_cout;
          end
        endcase
        result_d[int'(k_q)*CHUNK +: CHUNK] = chunk_res;
        if (k_q == KW'(NCHUNK - 1)) begin
          zf_d    = (result_d == '0);
          sf_d    = result_d[WIDTH-1];
          // b_q holds ~b for SUB, so one "same-sign operands" test covers both ops.
          of_d    = is_arith && (a_q[WIDTH-1] == b_q[WIDTH-1])
                             && (result_d[WIDTH-1] != a_q[WIDTH-1]);
          cf_d    = is_arith && chunk_cout;
          state_d = S_DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= ALU_ADD;
      a_q      <= '0;
      b_q      <= '0;
      k_q      <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      zf_q     <= 1'b0;
      sf_q     <= 1'b0;
      of_q     <= 1'b0;
      cf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      k_q      <= k_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      zf_q     <= zf_d;
      sf_q     <= sf_d;
      of_q     <= of_d;
      cf_q     <= cf_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.zf        = zf_q;
  assign bus.sf        = sf_q;
  assign bus.of        = of_q;
  assign bus.cf        = cf_q;
endmodule
